// File: rtl/scr_sync_trigger.sv
// Line-synchronised SCR firing trigger: zero-cross filter, period/lock tracker, delay-and-fire FSM.
// Define SCR_SYNC_HOLDOFF_EN to ignore filtered rising edges for PERIOD_MIN/2 cycles after each event.
module scr_sync_trigger #(
    parameter int FILT_LEN   = 2500,
    parameter int PERIOD_MIN = 900000,
    parameter int PERIOD_MAX = 1100000,
    parameter int PULSE_LEN  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ZC_IN,
    input  logic        RUN,
    input  logic [23:0] ALPHA,
    input  logic        CLR_MISS,
    output logic        START,
    output logic        ZC_EVT,
    output logic        LOCKED,
    output logic [23:0] PERIOD,
    output logic        MISS
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILT_LEN - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [23:0]   P_MIN      = 24'(PERIOD_MIN);
    localparam logic [23:0]   P_MAX      = 24'(PERIOD_MAX);
    localparam logic [23:0]   ALPHA_MAX  = 24'(PERIOD_MIN - 1);

    typedef enum logic [1:0] {IDLE, DELAY, FIRE} state_t;

    logic          sync1, sync2, filt, filt_prev, edge_ok;
    logic [FW-1:0] filt_cnt;
    logic          seen, in_window, timeout, locked_nxt;
    logic [23:0]   per_cnt;
    logic [1:0]    lock_cnt, lock_cnt_nxt;
    state_t        state, state_nxt;
    logic [23:0]   dly_cnt, dly_nxt, alpha_c;
    logic [PW-1:0] pulse_cnt, pulse_nxt;
    logic          arm, load, miss_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            filt      <= 1'b0;
            filt_prev <= 1'b0;
            filt_cnt  <= '0;
            ZC_EVT    <= 1'b0;
        end else begin
            sync1 <= ZC_IN;
            sync2 <= sync1;
            if (sync2 != filt) begin
                if (filt_cnt == FILT_LAST) begin
                    filt     <= sync2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
            filt_prev <= filt;
            ZC_EVT    <= filt & ~filt_prev & edge_ok;
        end
    end

`ifdef SCR_SYNC_HOLDOFF_EN
    localparam logic [23:0] HOLD_LEN = 24'(PERIOD_MIN / 2);
    logic [23:0] hold_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_cnt <= '0;
        end else if (ZC_EVT) begin
            hold_cnt <= HOLD_LEN;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 24'd1;
        end
    end

    assign edge_ok = (hold_cnt == '0);
`else
    assign edge_ok = 1'b1;
`endif

    assign in_window = (per_cnt >= P_MIN) && (per_cnt <= P_MAX);
    assign timeout   = seen && (per_cnt > P_MAX);

    // The firing FSM needs the lock state as updated by the current event.
    always_comb begin
        lock_cnt_nxt = lock_cnt;
        locked_nxt   = LOCKED;
        if (ZC_EVT && seen) begin
            if (in_window) begin
                lock_cnt_nxt = (lock_cnt == 2'd3) ? 2'd3 : lock_cnt + 2'd1;
                locked_nxt   = (lock_cnt_nxt == 2'd3);
            end else begin
                lock_cnt_nxt = '0;
                locked_nxt   = 1'b0;
            end
        end else if (timeout) begin
            lock_cnt_nxt = '0;
            locked_nxt   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seen     <= 1'b0;
            per_cnt  <= '0;
            PERIOD   <= '0;
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            LOCKED   <= locked_nxt;
            if (ZC_EVT) begin
                seen    <= 1'b1;
                per_cnt <= 24'd1;
                if (seen) begin
                    PERIOD <= per_cnt;
                end
            end else if (seen && per_cnt != '1) begin
                per_cnt <= per_cnt + 24'd1;
            end
        end
    end

    assign alpha_c  = (ALPHA >= P_MIN) ? ALPHA_MAX : ALPHA;
    assign arm      = ZC_EVT && RUN && locked_nxt;
    assign miss_set = ZC_EVT && (state != IDLE);

    // Loading the delay counter with 0 goes straight to FIRE so START follows ZC_EVT by ALPHA+1 cycles.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        pulse_nxt = pulse_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                load = arm;
            end
            DELAY: begin
                if (ZC_EVT) begin
                    load = arm;
                    if (!arm) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    dly_nxt = dly_cnt - 24'd1;
                    if (dly_cnt == 24'd1) begin
                        state_nxt = FIRE;
                        pulse_nxt = '0;
                    end
                end
            end
            FIRE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    pulse_nxt = pulse_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            dly_nxt   = alpha_c;
            pulse_nxt = '0;
            state_nxt = (alpha_c == '0) ? FIRE : DELAY;
        end
        if (!RUN || timeout) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            pulse_cnt <= '0;
            MISS      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_nxt;
            pulse_cnt <= pulse_nxt;
            MISS      <= miss_set | (MISS & ~CLR_MISS);
        end
    end

    assign START = (state == FIRE);

endmodule

// File: tb/tb_scr_sync_trigger.sv
// Directed bench for scr_sync_trigger using scaled-down timing parameters.
module tb_scr_sync_trigger;

    localparam int FILT = 5;
    localparam int PMIN = 90;
    localparam int PMAX = 110;
    localparam int PLEN = 4;

    logic        clk = 1'b0;
    logic        rst, zc_in, run, clr_miss;
    logic [23:0] alpha;
    logic        start, zc_evt, locked, miss;
    logic [23:0] period;

    int checks = 0;
    int errors = 0;

    int cyc = 0, evt_n = 0, last_evt = 0, evt_long = 0;
    int start_rises = 0, start_at = 0, start_delay = 0, start_width = 0;
    int lock_rise_evt = 0, lock_fall_delay = 0, miss_clr_n = 0;
    bit start_q = 1'b0, locked_q = 1'b0, evt_q = 1'b0;

    always #5 clk = ~clk;

    scr_sync_trigger #(
        .FILT_LEN  (FILT),
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .PULSE_LEN (PLEN)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .ZC_IN   (zc_in),
        .RUN     (run),
        .ALPHA   (alpha),
        .CLR_MISS(clr_miss),
        .START   (start),
        .ZC_EVT  (zc_evt),
        .LOCKED  (locked),
        .PERIOD  (period),
        .MISS    (miss)
    );

    // Timestamps are taken in the middle of each clock cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            evt_n         <= 0;
            start_rises   <= 0;
            lock_rise_evt <= 0;
            start_q       <= 1'b0;
            locked_q      <= 1'b0;
            evt_q         <= 1'b0;
        end else begin
            if (zc_evt) begin
                if (evt_q) evt_long <= evt_long + 1;
                evt_n    <= evt_n + 1;
                last_evt <= cyc;
            end
            if (start && !start_q) begin
                start_rises <= start_rises + 1;
                start_at    <= cyc;
                start_delay <= cyc - last_evt;
            end
            if (!start && start_q) start_width <= cyc - start_at;
            if (locked && !locked_q) lock_rise_evt <= evt_n;
            if (!locked && locked_q) lock_fall_delay <= cyc - last_evt;
            if (miss && clr_miss) miss_clr_n <= miss_clr_n + 1;
            start_q  <= start;
            locked_q <= locked;
            evt_q    <= zc_evt;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic zc_period(input int p);
        zc_in = 1'b1;
        step(p / 2);
        zc_in = 1'b0;
        step(p - p / 2);
    endtask

    task automatic do_reset;
        zc_in = 1'b0;
        rst   = 1'b1;
        step(2);
        rst   = 1'b0;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int m0;
        bit found;

        rst = 1'b1; zc_in = 1'b0; run = 1'b0; alpha = '0; clr_miss = 1'b0;
        step(1);
        check_eq("rst_start", start, 0);
        check_eq("rst_zc_evt", zc_evt, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_miss", miss, 0);
        rst = 1'b0;
        step(2);

        // Glitches shorter than the filter, then one long high.
        run = 1'b1; alpha = 24'd10;
        for (int i = 0; i < 3; i++) begin
            zc_in = 1'b1; step(FILT - 1);
            zc_in = 1'b0; step(10);
        end
        check_eq("glitch_no_evt", evt_n, 0);
        zc_in = 1'b1; step(8);
        zc_in = 1'b0; step(20);
        check_eq("long_high_evt", evt_n, 1);

        // Lock acquisition and steady firing.
        do_reset();
        zc_period(100);
        check_eq("first_evt_no_period", period, 0);
        zc_period(100);
        zc_period(100);
        check_eq("not_locked_3rd_evt", locked, 0);
        zc_period(100);
        check_eq("locked_4th_evt", locked, 1);
        check_eq("lock_rise_evt", lock_rise_evt, 4);
        zc_period(100);
        zc_period(100);
        check_eq("start_count", start_rises, 3);
        check_eq("start_delay", start_delay, 11);
        check_eq("start_width", start_width, PLEN);
        check_eq("period_100", period, 100);

        // One short period drops lock; three good ones relock.
        n0 = start_rises;
        zc_period(80);
        zc_period(100);
        check_eq("unlock_short", locked, 0);
        check_eq("period_80", period, 80);
        check_eq("no_start_short", start_rises, n0 + 1);
        zc_period(100);
        zc_period(100);
        check_eq("relock_early", locked, 0);
        zc_period(100);
        check_eq("relock", locked, 1);

        // ALPHA clamp and zero delay.
        alpha = 24'd200;
        zc_period(100);
        check_eq("clamp_delay", start_delay, PMIN);
        alpha = 24'd0;
        zc_period(100);
        check_eq("alpha0_delay", start_delay, 1);
        check_eq("alpha0_width", start_width, PLEN);

        // Event during FIRE sets MISS and does not retrigger.
        alpha = 24'(PMIN - 1);
        n0 = start_rises;
        zc_period(90);
        zc_period(90);
        check_eq("miss_in_fire", miss, 1);
        check_eq("no_retrigger", start_rises, n0 + 1);
        check_eq("fire_completes", start_width, PLEN);
        clr_miss = 1'b1;
        step(2);
        check_eq("miss_clear", miss, 0);
        m0 = miss_clr_n;
        zc_period(90);
        zc_period(90);
        check_eq("miss_set_wins", miss_clr_n - m0, 1);
        check_eq("miss_cleared_after", miss, 0);
        clr_miss = 1'b0;

        // RUN dropped during DELAY cancels the firing.
        alpha = 24'd50;
        n0 = start_rises;
        zc_in = 1'b1; step(30);
        run = 1'b0;   step(20);
        zc_in = 1'b0; step(50);
        run = 1'b1;
        check_eq("run_off_no_start", start_rises, n0);

        // Zero-cross stuck low: lock times out.
        step(150);
        check_eq("timeout_unlock", locked, 0);
        check_eq("timeout_delay", lock_fall_delay, PMAX + 2);
        check_eq("period_held", period, 90);

        // Event latency and a second edge 20 cycles after an event.
        do_reset();
        run = 1'b0;
        zc_in = 1'b1;
        step(7);
        check_eq("evt_latency_early", zc_evt, 0);
        step(1);
        check_eq("evt_latency", zc_evt, 1);
        step(2);
        zc_in = 1'b0; step(10);
        zc_in = 1'b1; step(10);
        zc_in = 1'b0; step(20);
`ifdef SCR_SYNC_HOLDOFF_EN
        check_eq("second_edge", evt_n, 1);
`else
        check_eq("second_edge", evt_n, 2);
`endif
        check_eq("evt_one_cycle", evt_long, 0);

        // Reset asserted while START is high.
        do_reset();
        run = 1'b1; alpha = 24'd0;
        zc_period(100);
        zc_period(100);
        zc_period(100);
        zc_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (start) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("fire_reached", found, 1);
        check_eq("fire_delay_alpha0", start_delay, 1);
        check_eq("locked_before_rst", locked, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_fire_start", start, 0);
        check_eq("rst_fire_locked", locked, 0);
        check_eq("rst_fire_period", period, 0);
        zc_in = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
